// File: rtl/usb20_nrzi_tx.sv
// usb20_nrzi_tx: USB 2.0 full-speed serial transmitter.
// Takes a byte stream on a valid/ready handshake and emits SYNC, bit-stuffed NRZI
// data and EOP. It drives both the dp/dn pin pair and the tx_d/tx_se0 encoded pair.
// Optional feature macro: USB20_TX_LS_EN adds the ls_mode_i port. With it, a packet
// can use low-speed timing (8x bit period) and swapped J/K polarity.
module usb20_nrzi_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       err_underrun_o,
  output logic       dp_o,
  output logic       dn_o,
  output logic       oe_o,
  output logic       tx_d_o,
`ifdef USB20_TX_LS_EN
  output logic       tx_se0_o,
  input  logic       ls_mode_i
`else
  output logic       tx_se0_o
`endif
);

  // Bit-period counter sizing: the longest period is the low-speed one when enabled.
`ifdef USB20_TX_LS_EN
  localparam int PER_MAX = 8 * CLKS_PER_BIT;
`else
  localparam int PER_MAX = CLKS_PER_BIT;
`endif
  localparam int CW = $clog2(PER_MAX);
  localparam int EW = $clog2(EOP_SE0_BITS + 1);

  localparam logic [CW-1:0] FS_PER_M1 = CW'(CLKS_PER_BIT - 1);
`ifdef USB20_TX_LS_EN
  localparam logic [CW-1:0] LS_PER_M1 = CW'(8 * CLKS_PER_BIT - 1);
`endif
  localparam logic [EW-1:0] EOP_LEN   = EW'(EOP_SE0_BITS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_STUFF   = 3'd3,
    ST_EOP_SE0 = 3'd4,
    ST_EOP_J   = 3'd5
  } state_e;

  // One NRZI bit: a 0 toggles the line and clears the run of ones, a 1 holds the line
  // and extends the run. Returns {line_j, ones}.
  function automatic logic [3:0] nrzi_step(input logic line_j, input logic [2:0] ones,
                                           input logic b);
    logic [3:0] r;
    if (b) begin
      r = {line_j, ones + 3'd1};
    end else begin
      r = {~line_j, 3'd0};
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;   // bits of current byte / SYNC already driven
  logic [2:0]    ones_q, ones_d;         // consecutive ones on the wire
  logic [EW-1:0] eop_cnt_q, eop_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic          ls_q, ls_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          oe_q, oe_d;
  logic          line_j_q, line_j_d;     // 1 = line in J state
  logic          se0_q, se0_d;
  logic          dp_q, dp_d;
  logic          dn_q, dn_d;
  logic          tx_d_q, tx_d_d;
  logic          tx_se0_q, tx_se0_d;

  logic          ls_sel_s;
  logic [CW-1:0] per_m1_s;
  logic          strobe_s;
  logic          pre_strobe_s;
  logic [3:0]    step_s;
  logic          nxt_bit_s;

`ifdef USB20_TX_LS_EN
  assign ls_sel_s = ls_mode_i;
  assign per_m1_s = ls_q ? LS_PER_M1 : FS_PER_M1;
`else
  assign ls_sel_s = 1'b0;
  assign per_m1_s = FS_PER_M1;
`endif

  // The strobe is the counter wrap; the cycle before it is where a next byte is requested.
  assign strobe_s     = (cnt_q == per_m1_s);
  assign pre_strobe_s = (cnt_q == (per_m1_s - CW'(1)));

  // Next data bit of the byte in flight, and its NRZI result.
  assign nxt_bit_s = shift_q[bit_idx_q[2:0]];
  assign step_s    = nrzi_step(line_j_q, ones_q, nxt_bit_s);

  // Next-state logic for the transmit FSM, bit timing and line encoding.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    eop_cnt_d = eop_cnt_q;
    shift_d   = shift_q;
    last_d    = last_q;
    ls_d      = ls_q;
    ready_d   = 1'b0;
    busy_d    = busy_q;
    oe_d      = oe_q;
    line_j_d  = line_j_q;
    se0_d     = se0_q;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
    end else if (strobe_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (ready_q && valid_i) begin
          // Handshake: latch the first byte and drive SYNC bit 0 (K) right away.
          shift_d   = data_i;
          last_d    = last_i;
          ls_d      = ls_sel_s;
          state_d   = ST_SYNC;
          oe_d      = 1'b1;
          busy_d    = 1'b1;
          line_j_d  = 1'b0;
          se0_d     = 1'b0;
          bit_idx_d = 4'd1;
          ones_d    = 3'd0;
          cnt_d     = '0;
        end else begin
          ready_d  = 1'b1;
          oe_d     = 1'b0;
          busy_d   = 1'b0;
          line_j_d = 1'b1;
          se0_d    = 1'b0;
        end
      end

      ST_SYNC: begin
        if (strobe_s) begin
          if (bit_idx_q == 4'd8) begin
            // SYNC complete: first data bit; the trailing SYNC '1' already counts as a one.
            {line_j_d, ones_d} = step_s;
            bit_idx_d          = 4'd1;
            state_d            = ST_DATA;
          end else begin
            // SYNC pattern 8'h80 LSB first: zeros except the last bit.
            {line_j_d, ones_d} = nrzi_step(line_j_q, ones_q, (bit_idx_q == 4'd7));
            bit_idx_d          = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_DATA, ST_STUFF: begin
        // Request the next byte one cycle before the strobe that would start its bit 0.
        if (pre_strobe_s && (ones_q != 3'd6) && (bit_idx_q == 4'd8) && !last_q) begin
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
        if (strobe_s) begin
          if (ones_q == 3'd6) begin
            // Six ones in a row: insert a forced toggle.
            line_j_d = ~line_j_q;
            ones_d   = 3'd0;
            state_d  = ST_STUFF;
          end else if (bit_idx_q != 4'd8) begin
            {line_j_d, ones_d} = step_s;
            bit_idx_d          = bit_idx_q + 4'd1;
            state_d            = ST_DATA;
          end else if (!last_q && ready_q && valid_i) begin
            // Next byte accepted with zero gap.
            shift_d            = data_i;
            last_d             = last_i;
            {line_j_d, ones_d} = nrzi_step(line_j_q, ones_q, data_i[0]);
            bit_idx_d          = 4'd1;
            state_d            = ST_DATA;
          end else begin
            // End of packet, or underrun truncating it.
            se0_d     = 1'b1;
            eop_cnt_d = EW'(1);
            state_d   = ST_EOP_SE0;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_EOP_SE0: begin
        if (strobe_s) begin
          if (eop_cnt_q == EOP_LEN) begin
            se0_d    = 1'b0;
            line_j_d = 1'b1;
            state_d  = ST_EOP_J;
          end else begin
            eop_cnt_d = eop_cnt_q + EW'(1);
          end
        end else begin
          state_d = ST_EOP_SE0;
        end
      end

      ST_EOP_J: begin
        if (strobe_s) begin
          state_d  = ST_IDLE;
          oe_d     = 1'b0;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
          line_j_d = 1'b1;
        end else begin
          state_d = ST_EOP_J;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        oe_d     = 1'b0;
        busy_d   = 1'b0;
        line_j_d = 1'b1;
        se0_d    = 1'b0;
      end
    endcase

    // Pin encoding: J is dp1/dn0 at full speed and swapped at low speed; SE0 is both low.
    if (se0_d) begin
      dp_d   = 1'b0;
      dn_d   = 1'b0;
      tx_d_d = tx_d_q;
    end else begin
      dp_d   = line_j_d ^ ls_d;
      dn_d   = ~(line_j_d ^ ls_d);
      tx_d_d = line_j_d ^ ls_d;
    end
    tx_se0_d = se0_d;
  end

  // State and registered outputs; async reset returns the line to idle immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 4'd0;
      ones_q    <= 3'd0;
      eop_cnt_q <= '0;
      shift_q   <= 8'h00;
      last_q    <= 1'b0;
      ls_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      line_j_q  <= 1'b1;
      se0_q     <= 1'b0;
      dp_q      <= 1'b1;
      dn_q      <= 1'b0;
      tx_d_q    <= 1'b1;
      tx_se0_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      eop_cnt_q <= eop_cnt_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      ls_q      <= ls_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      oe_q      <= oe_d;
      line_j_q  <= line_j_d;
      se0_q     <= se0_d;
      dp_q      <= dp_d;
      dn_q      <= dn_d;
      tx_d_q    <= tx_d_d;
      tx_se0_q  <= tx_se0_d;
    end
  end

  assign ready_o        = ready_q;
  assign busy_o         = busy_q;
  // Underrun is flagged in the request cycle itself, so it must see valid_i directly.
  assign err_underrun_o = ready_q & busy_q & ~valid_i;
  assign dp_o           = dp_q;
  assign dn_o           = dn_q;
  assign oe_o           = oe_q;
  assign tx_d_o         = tx_d_q;
  assign tx_se0_o       = tx_se0_q;

endmodule

// File: tb/tb_usb20_nrzi_tx.sv
// Self-checking bench for usb20_nrzi_tx: a reference model pushes the expected line
// symbols and packet statistics when a packet is driven; a monitor pops and compares
// them while oe_o is high.
module tb_usb20_nrzi_tx;
  localparam int CPB = 4;
  localparam int EOPB = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] data;
  logic valid, last;
  logic ready_o, busy_o, err_underrun_o, dp_o, dn_o, oe_o, tx_d_o, tx_se0_o;
`ifdef USB20_TX_LS_EN
  logic ls_mode;
`endif

  usb20_nrzi_tx #(.CLKS_PER_BIT(CPB), .EOP_SE0_BITS(EOPB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid), .last_i(last),
    .ready_o(ready_o), .busy_o(busy_o), .err_underrun_o(err_underrun_o),
    .dp_o(dp_o), .dn_o(dn_o), .oe_o(oe_o), .tx_d_o(tx_d_o),
`ifdef USB20_TX_LS_EN
    .ls_mode_i(ls_mode),
`endif
    .tx_se0_o(tx_se0_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard queues
  logic [1:0] sym_q[$];
  int len_q[$];
  int per_q[$];
  int pls_q[$];
  int err_q[$];
  logic [1:0] idle_q[$];
  logic [7:0] pb [8];
  int pkts_exp = 0;
  int pkts_done = 0;
  bit mon_en = 1'b1;
  bit cur_ls = 1'b0;

  function automatic logic [1:0] sym_of(input logic j, input bit ls);
    logic [1:0] s;
    if (j) s = ls ? 2'b01 : 2'b10;
    else   s = ls ? 2'b10 : 2'b01;
    return s;
  endfunction

  // Reference model: SYNC, NRZI data with stuffing, EOP.
  task automatic model_push(input int n, input bit drop, input bit ls);
    logic j;
    int ones, bits, per;
    logic [7:0] b;
    logic [7:0] sync_b;
    j = 1'b1; ones = 0; bits = 0;
    sync_b = 8'h80;
    per = ls ? 8 * CPB : CPB;
    for (int i = 0; i < 8; i++) begin
      if (!sync_b[i]) begin j = ~j; ones = 0; end else ones++;
      sym_q.push_back(sym_of(j, ls)); bits++;
    end
    for (int k = 0; k < n; k++) begin
      b = pb[k];
      for (int i = 0; i < 8; i++) begin
        if (!b[i]) begin j = ~j; ones = 0; end else ones++;
        sym_q.push_back(sym_of(j, ls)); bits++;
        if (ones == 6) begin
          j = ~j; ones = 0;
          sym_q.push_back(sym_of(j, ls)); bits++;
        end
      end
    end
    for (int i = 0; i < EOPB; i++) begin sym_q.push_back(2'b00); bits++; end
    sym_q.push_back(sym_of(1'b1, ls)); bits++;
    len_q.push_back(bits * per);
    per_q.push_back(per);
    pls_q.push_back(n - 1 + (drop ? 1 : 0));
    err_q.push_back(drop ? 1 : 0);
    idle_q.push_back(sym_of(1'b1, ls));
    pkts_exp++;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!ready_o && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_o || !ready_o) && k < 3000) begin @(negedge clk); k++; end
    if (k >= 3000) check_eq("timeout_idle", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pkt(input int n, input bit drop);
    model_push(n, drop, cur_ls);
    @(negedge clk);
    data = pb[0]; last = (n == 1) && !drop; valid = 1'b1;
    wait_ready("timeout_hs0");
    @(posedge clk);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      data = pb[i]; last = (i == n - 1) && !drop; valid = 1'b1;
      wait_ready("timeout_hs");
      @(posedge clk);
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    if (drop) begin
      wait_ready("timeout_underrun");
      check_eq("underrun_err", err_underrun_o, 1);
      @(negedge clk);
      check_eq("underrun_err_end", err_underrun_o, 0);
    end
    wait_idle();
  endtask

  // Monitor: compares the line every cycle oe_o is high, packet stats when it falls.
  initial begin
    bit in_pkt = 0;
    int cyc = 0, pulses = 0, errs = 0, busy_cyc = 0;
    int e_len = 0, e_per = 1, e_pls = 0, e_err = 0;
    logic [1:0] e_idle = 2'b10;
    logic [1:0] cur = 2'b11;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_pkt = 0;
      end else if (oe_o) begin
        if (!in_pkt) begin
          in_pkt = 1; cyc = 0; pulses = 0; errs = 0; busy_cyc = 0;
          if (len_q.size() == 0) begin
            check_eq("pkt_unexpected", 32'd1, 32'd0);
            e_len = 0; e_per = CPB; e_pls = 0; e_err = 0; e_idle = 2'b10;
          end else begin
            e_len = len_q.pop_front(); e_per = per_q.pop_front();
            e_pls = pls_q.pop_front(); e_err = err_q.pop_front();
            e_idle = idle_q.pop_front();
          end
        end
        if (cyc % e_per == 0) begin
          if (sym_q.size() > 0) cur = sym_q.pop_front();
          else cur = 2'b11;
        end
        check_eq("line", {30'd0, dp_o, dn_o}, {30'd0, cur});
        check_eq("tx_se0", tx_se0_o, (cur == 2'b00));
        if (cur != 2'b00) check_eq("tx_d", tx_d_o, dp_o);
        cyc++;
        if (ready_o) pulses++;
        if (err_underrun_o) errs++;
        if (busy_o) busy_cyc++;
      end else if (in_pkt) begin
        in_pkt = 0;
        check_eq("oe_len", cyc, e_len);
        check_eq("busy_len", busy_cyc, e_len);
        check_eq("ready_pulses", pulses, e_pls);
        check_eq("err_pulses", errs, e_err);
        check_eq("idle_ready", ready_o, 1);
        check_eq("idle_busy", busy_o, 0);
        check_eq("idle_pins", {30'd0, dp_o, dn_o}, {30'd0, e_idle});
        pkts_done++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00;
`ifdef USB20_TX_LS_EN
    ls_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_err", err_underrun_o, 0);
    check_eq("rst_oe", oe_o, 0);
    check_eq("rst_dp", dp_o, 1);
    check_eq("rst_dn", dn_o, 0);
    check_eq("rst_tx_d", tx_d_o, 1);
    check_eq("rst_tx_se0", tx_se0_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", ready_o, 1);

    // T1: single 8'h00
    pb[0] = 8'h00; send_pkt(1, 0);
    // T2: single 8'hFF, stuff bit inside the byte
    pb[0] = 8'hFF; send_pkt(1, 0);
    // T3: back-to-back bytes
    pb[0] = 8'hA5; pb[1] = 8'h3C; send_pkt(2, 0);
    // T4: underrun after first byte
    pb[0] = 8'h01; send_pkt(1, 1);
    // Stuffing across byte boundaries and before EOP
    pb[0] = 8'hFF; pb[1] = 8'hFF; pb[2] = 8'h7E; send_pkt(3, 0);
    pb[0] = 8'hFC; pb[1] = 8'hFF; send_pkt(2, 0);
    // Random bytes
    for (int i = 0; i < 4; i++) pb[i] = 8'($urandom_range(0, 255));
    send_pkt(4, 0);

    // T5: reset in the middle of DATA
    mon_en = 1'b0;
    @(negedge clk);
    data = 8'h00; last = 1'b0; valid = 1'b1;
    wait_ready("timeout_t5");
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (45) @(negedge clk);
    check_eq("t5_oe_before", oe_o, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_oe", oe_o, 0);
    check_eq("t5_busy", busy_o, 0);
    check_eq("t5_dp", dp_o, 1);
    check_eq("t5_dn", dn_o, 0);
    check_eq("t5_se0", tx_se0_o, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_eq("t5_ready", ready_o, 1);
    mon_en = 1'b1;
    pb[0] = 8'h5A; send_pkt(1, 0);

`ifdef USB20_TX_LS_EN
    // T6: low-speed packet
    ls_mode = 1'b1; cur_ls = 1'b1;
    pb[0] = 8'h00; send_pkt(1, 0);
    ls_mode = 1'b0; cur_ls = 1'b0;
    pb[0] = 8'h81; send_pkt(1, 0);
`endif

    repeat (4) @(negedge clk);
    check_eq("pkt_count", pkts_done, pkts_exp);
    check_eq("sym_left", sym_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end
endmodule
